operand_forward_stage: RTL and testbench

//  Parametrised ID->EX operand stage for the LoongArch pipeline. Resolves NSRC source operands

---
 rtl/la_pipe_pkg.sv | 12 +
 rtl/fwd_select.sv | 46 ++++
 rtl/operand_forward_stage.sv | 126 ++++++++++++
 tb/tb_operand_forward_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pipe_pkg.sv
// Shared LoongArch pipeline definitions: datapath widths, the hard-zero register
// and the load-use interlock state encoding.
package la_pipe_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef enum logic {
    RUN     = 1'b0,
    LU_WAIT = 1'b1
  } lu_state_e;
endpackage

// File: rtl/fwd_select.sv
// Purpose: resolve one source operand with EX > MEM > WB forwarding and $r0 forced to zero.
// Latency: purely combinational.
// Backpressure: none; the enclosing stage decides when the result is captured.
module fwd_select #(
  parameter int XLEN = la_pipe_pkg::XLEN,
  parameter int AW   = la_pipe_pkg::AW
) (
  input  logic            is_rs,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] other_data,
  input  logic            ex_wr_en,
  input  logic [AW-1:0]   ex_wr_addr,
  input  logic [XLEN-1:0] ex_wr_data,
  input  logic            mem_wr_en,
  input  logic [AW-1:0]   mem_wr_addr,
  input  logic [XLEN-1:0] mem_wr_data,
  input  logic            wb_wr_en,
  input  logic [AW-1:0]   wb_wr_addr,
  input  logic [XLEN-1:0] wb_wr_data,
  output logic            match_ex,
  output logic [XLEN-1:0] true_rs,
  output logic [XLEN-1:0] operand
);
  import la_pipe_pkg::*;

  logic addr_nz;
  logic match_mem;
  logic match_wb;

  // Writes to $r0 are never forwarded, so a zero address cannot match any stage.
  assign addr_nz   = (addr != AW'(REG_ZERO));
  assign match_ex  = ex_wr_en  & (ex_wr_addr  == addr) & addr_nz;
  assign match_mem = mem_wr_en & (mem_wr_addr == addr) & addr_nz;
  assign match_wb  = wb_wr_en  & (wb_wr_addr  == addr) & addr_nz;

  always_comb begin
    true_rs = rs_data;
    if (!addr_nz)       true_rs = '0;
    else if (match_ex)  true_rs = ex_wr_data;
    else if (match_mem) true_rs = mem_wr_data;
    else if (match_wb)  true_rs = wb_wr_data;
  end

  assign operand = is_rs ? true_rs : other_data;
endmodule

// File: rtl/operand_forward_stage.sv
// Purpose: ID->EX operand stage with forwarding, load-use interlock and output register.
// Latency: 1 cycle ID->EX; load-use hazards add LOAD_LAT+1 stall cycles.
// Backpressure: ex_valid & ~ex_ready holds the output register and drops id_ready.
module operand_forward_stage #(
  parameter int NSRC     = 2,
  parameter int XLEN     = la_pipe_pkg::XLEN,
  parameter int AW       = la_pipe_pkg::AW,
  parameter int LOAD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [NSRC-1:0]      id_is_rs,
  input  logic [NSRC*AW-1:0]   id_rs_addr,
  input  logic [NSRC*XLEN-1:0] id_rs_data,
  input  logic [NSRC*XLEN-1:0] id_other_data,
  input  logic                 ex_wr_en,
  input  logic                 ex_is_load,
  input  logic [AW-1:0]        ex_wr_addr,
  input  logic [XLEN-1:0]      ex_wr_data,
  input  logic                 mem_wr_en,
  input  logic [AW-1:0]        mem_wr_addr,
  input  logic [XLEN-1:0]      mem_wr_data,
  input  logic                 wb_wr_en,
  input  logic [AW-1:0]        wb_wr_addr,
  input  logic [XLEN-1:0]      wb_wr_data,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [NSRC*XLEN-1:0] ex_true_rs,
  output logic [NSRC*XLEN-1:0] ex_operand,
  output logic                 lu_stall
);
  import la_pipe_pkg::*;

  localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

  lu_state_e             state, state_nxt;
  logic [1:0]            cnt, cnt_nxt;
  logic [NSRC-1:0]       match_ex;
  logic [NSRC*XLEN-1:0]  true_rs;
  logic [NSRC*XLEN-1:0]  operand;
  logic                  hazard;
  logic                  capture;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    fwd_select #(.XLEN(XLEN), .AW(AW)) u_fwd (
      .is_rs       (id_is_rs[gi]),
      .addr        (id_rs_addr[gi*AW +: AW]),
      .rs_data     (id_rs_data[gi*XLEN +: XLEN]),
      .other_data  (id_other_data[gi*XLEN +: XLEN]),
      .ex_wr_en    (ex_wr_en),
      .ex_wr_addr  (ex_wr_addr),
      .ex_wr_data  (ex_wr_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .wb_wr_en    (wb_wr_en),
      .wb_wr_addr  (wb_wr_addr),
      .wb_wr_data  (wb_wr_data),
      .match_ex    (match_ex[gi]),
      .true_rs     (true_rs[gi*XLEN +: XLEN]),
      .operand     (operand[gi*XLEN +: XLEN])
    );
  end

  // Only sources that actually read a register can depend on the load in EX.
  assign hazard  = id_valid & ex_is_load & (|(id_is_rs & match_ex));
  assign capture = id_valid & id_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lu_stall  = 1'b0;
    id_ready  = 1'b0;
    case (state)
      RUN: begin
        lu_stall = hazard;
        id_ready = ~hazard & (~ex_valid | ex_ready) & ~flush;
        if (hazard) begin
          state_nxt = LU_WAIT;
          cnt_nxt   = CNT_INIT;
        end
      end
      LU_WAIT: begin
        // The waited-on load has left EX by the time we exit; no re-check against it.
        lu_stall = 1'b1;
        if (cnt == 2'd0) state_nxt = RUN;
        else             cnt_nxt   = cnt - 2'd1;
      end
      default: state_nxt = RUN;
    endcase
    if (flush) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Flush only kills the valid bit; the data registers keep their last contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_true_rs <= '0;
      ex_operand <= '0;
    end else begin
      if (flush)         ex_valid <= 1'b0;
      else if (capture)  ex_valid <= 1'b1;
      else if (ex_ready) ex_valid <= 1'b0;
      if (capture) begin
        ex_true_rs <= true_rs;
        ex_operand <= operand;
      end
    end
  end
endmodule

// File: tb/tb_operand_forward_stage.sv
// Directed bench for operand_forward_stage: vector table for forwarding, hand-written
// sequences for interlock, backpressure, flush and reset, plus a small random sweep.
module tb_operand_forward_stage;
  logic        clk = 1'b0;
  logic        rst, flush, id_valid, ex_ready;
  logic [1:0]  id_is_rs;
  logic [9:0]  id_rs_addr;
  logic [63:0] id_rs_data, id_other_data;
  logic        ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en;
  logic [4:0]  ex_wr_addr, mem_wr_addr, wb_wr_addr;
  logic [31:0] ex_wr_data, mem_wr_data, wb_wr_data;

  logic        id_ready1, ex_valid1, lu_stall1;
  logic [63:0] ex_true_rs1, ex_operand1;
  logic        id_ready2, ex_valid2, lu_stall2;
  logic [63:0] ex_true_rs2, ex_operand2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  operand_forward_stage #(.NSRC(2), .XLEN(32), .AW(5), .LOAD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready1),
    .id_is_rs(id_is_rs), .id_rs_addr(id_rs_addr), .id_rs_data(id_rs_data),
    .id_other_data(id_other_data), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .wb_wr_en(wb_wr_en),
    .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data), .ex_valid(ex_valid1),
    .ex_ready(ex_ready), .ex_true_rs(ex_true_rs1), .ex_operand(ex_operand1),
    .lu_stall(lu_stall1)
  );

  operand_forward_stage #(.NSRC(2), .XLEN(32), .AW(5), .LOAD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready2),
    .id_is_rs(id_is_rs), .id_rs_addr(id_rs_addr), .id_rs_data(id_rs_data),
    .id_other_data(id_other_data), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .wb_wr_en(wb_wr_en),
    .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data), .ex_valid(ex_valid2),
    .ex_ready(ex_ready), .ex_true_rs(ex_true_rs2), .ex_operand(ex_operand2),
    .lu_stall(lu_stall2)
  );

  typedef struct {
    logic [1:0]  is_rs;
    logic [4:0]  a0, a1;
    logic [31:0] rf0, rf1, oth0, oth1;
    logic        ex_en, ld;
    logic [4:0]  ex_a;
    logic [31:0] ex_d;
    logic        mem_en;
    logic [4:0]  mem_a;
    logic [31:0] mem_d;
    logic        wb_en;
    logic [4:0]  wb_a;
    logic [31:0] wb_d;
    logic [31:0] t0, t1, o0, o1;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stages();
    ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = 0; ex_wr_data = 0;
    mem_wr_en = 0; mem_wr_addr = 0; mem_wr_data = 0;
    wb_wr_en = 0; wb_wr_addr = 0; wb_wr_data = 0;
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; id_valid = 0; ex_ready = 1;
    id_is_rs = 0; id_rs_addr = 0; id_rs_data = 0; id_other_data = 0;
    clear_stages();
    tick(); tick();
    rst = 0;
  endtask

  task automatic apply(input vec_t v);
    id_is_rs = v.is_rs; id_rs_addr = {v.a1, v.a0};
    id_rs_data = {v.rf1, v.rf0}; id_other_data = {v.oth1, v.oth0};
    ex_wr_en = v.ex_en; ex_is_load = v.ld; ex_wr_addr = v.ex_a; ex_wr_data = v.ex_d;
    mem_wr_en = v.mem_en; mem_wr_addr = v.mem_a; mem_wr_data = v.mem_d;
    wb_wr_en = v.wb_en; wb_wr_addr = v.wb_a; wb_wr_data = v.wb_d;
  endtask

  // Reference forwarding rule for the random sweep, evaluated on the driven inputs.
  function automatic logic [31:0] mdl(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    if (ex_wr_en && ex_wr_addr == a) return ex_wr_data;
    if (mem_wr_en && mem_wr_addr == a) return mem_wr_data;
    if (wb_wr_en && wb_wr_addr == a) return wb_wr_data;
    return rf;
  endfunction

  initial begin
    logic [31:0] e0, e1;
    vecs[0] = '{2'b11, 5'd4, 5'd6, 32'h10, 32'h66, 32'h1000, 32'h2000,
                1'b1, 1'b0, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB, 1'b1, 5'd6, 32'hCC,
                32'hAA, 32'hCC, 32'hAA, 32'hCC};
    vecs[1] = '{2'b11, 5'd4, 5'd6, 32'h10, 32'h66, 32'h1000, 32'h2000,
                1'b0, 1'b0, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB, 1'b1, 5'd6, 32'hCC,
                32'hBB, 32'hCC, 32'hBB, 32'hCC};
    vecs[2] = '{2'b11, 5'd4, 5'd9, 32'h10, 32'h99, 32'h1000, 32'h2000,
                1'b1, 1'b0, 5'd7, 32'hAA, 1'b1, 5'd4, 32'hBB, 1'b1, 5'd4, 32'hDD,
                32'hBB, 32'h99, 32'hBB, 32'h99};
    vecs[3] = '{2'b01, 5'd0, 5'd0, 32'h77, 32'h88, 32'h1000, 32'h3000,
                1'b1, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h56, 1'b1, 5'd0, 32'h57,
                32'h0, 32'h0, 32'h0, 32'h3000};
    vecs[4] = '{2'b01, 5'd3, 5'd5, 32'h30, 32'h50, 32'h1000, 32'h5555,
                1'b1, 1'b1, 5'd5, 32'hEE, 1'b0, 5'd3, 32'h0, 1'b1, 5'd3, 32'h333,
                32'h333, 32'hEE, 32'h333, 32'h5555};
    vecs[5] = '{2'b10, 5'd8, 5'd8, 32'h80, 32'h81, 32'h1234ABCD, 32'h9,
                1'b0, 1'b0, 5'd8, 32'hAA, 1'b1, 5'd8, 32'h88, 1'b1, 5'd8, 32'h99,
                32'h88, 32'h88, 32'h1234ABCD, 32'h88};

    do_reset();
    #1;
    chk("rst_ex_valid", {ex_valid2, ex_valid1}, 0);
    chk("rst_true_rs", ex_true_rs1 | ex_true_rs2, 0);
    chk("rst_operand", ex_operand1 | ex_operand2, 0);
    chk("rst_lu_stall", {lu_stall2, lu_stall1}, 0);
    chk("rst_id_ready", {id_ready2, id_ready1}, 2'b11);

    // Table: back-to-back captures with ex_ready=1, so ex_valid stays high throughout.
    id_valid = 1;
    for (int i = 0; i < 6; i++) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("vec%0d_id_ready", i), id_ready1, 1);
      tick();
      chk($sformatf("vec%0d_ex_valid", i), ex_valid1, 1);
      chk($sformatf("vec%0d_true_rs", i), ex_true_rs1, {vecs[i].t1, vecs[i].t0});
      chk($sformatf("vec%0d_operand", i), ex_operand1, {vecs[i].o1, vecs[i].o0});
    end

    // Load-use with LOAD_LAT=1: two stall cycles, then capture from MEM.
    do_reset();
    id_valid = 1; id_is_rs = 2'b01; id_rs_addr = {5'd0, 5'd5}; id_rs_data = {32'h0, 32'hBAD};
    ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5; ex_wr_data = 32'hDEAD;
    #1;
    chk("lu1_c0_stall", lu_stall1, 1);
    chk("lu1_c0_ready", id_ready1, 0);
    tick();
    clear_stages();
    #1;
    chk("lu1_c1_stall", lu_stall1, 1);
    chk("lu1_c1_ready", id_ready1, 0);
    tick();
    mem_wr_en = 1; mem_wr_addr = 5; mem_wr_data = 32'h1234;
    #1;
    chk("lu1_c2_stall", lu_stall1, 0);
    chk("lu1_c2_ready", id_ready1, 1);
    tick();
    id_valid = 0;
    chk("lu1_ex_valid", ex_valid1, 1);
    chk("lu1_true_rs", ex_true_rs1[31:0], 32'h1234);

    // Load-use with LOAD_LAT=2: three stall cycles, then capture from WB.
    do_reset();
    id_valid = 1; id_is_rs = 2'b01; id_rs_addr = {5'd0, 5'd5}; id_rs_data = {32'h0, 32'hBAD};
    ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5; ex_wr_data = 32'hDEAD;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("lu2_c%0d_stall", c), lu_stall2, 1);
      chk($sformatf("lu2_c%0d_ready", c), id_ready2, 0);
      tick();
      clear_stages();
    end
    wb_wr_en = 1; wb_wr_addr = 5; wb_wr_data = 32'h5678;
    #1;
    chk("lu2_c3_stall", lu_stall2, 0);
    chk("lu2_c3_ready", id_ready2, 1);
    tick();
    id_valid = 0;
    chk("lu2_ex_valid", ex_valid2, 1);
    chk("lu2_true_rs", ex_true_rs2[31:0], 32'h5678);

    // Backpressure: hold A for three cycles, then B is captured when ex_ready returns.
    do_reset();
    id_valid = 1; id_is_rs = 2'b11; id_rs_addr = {5'd2, 5'd1};
    id_rs_data = {32'h22, 32'h11};
    tick();
    chk("bp_a_true_rs", ex_true_rs1, {32'h22, 32'h11});
    ex_ready = 0; id_rs_data = {32'h44, 32'h33};
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_c%0d_ready", c), id_ready1, 0);
      tick();
      chk($sformatf("bp_c%0d_valid", c), ex_valid1, 1);
      chk($sformatf("bp_c%0d_hold", c), ex_true_rs1, {32'h22, 32'h11});
    end
    ex_ready = 1;
    #1;
    chk("bp_release_ready", id_ready1, 1);
    tick();
    id_valid = 0;
    chk("bp_b_true_rs", ex_true_rs1, {32'h44, 32'h33});
    chk("bp_b_valid", ex_valid1, 1);
    tick();
    chk("bp_drain_valid", ex_valid1, 0);

    // Flush during LU_WAIT with an instruction parked in the output register.
    do_reset();
    id_valid = 1; id_is_rs = 2'b01; id_rs_addr = {5'd0, 5'd1}; id_rs_data = {32'h0, 32'h77};
    tick();
    ex_ready = 0; id_rs_addr = {5'd0, 5'd5};
    ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5;
    #1;
    chk("fl_hazard_stall", lu_stall2, 1);
    tick();
    flush = 1; clear_stages();
    #1;
    chk("fl_ready_during_flush", {id_ready2, id_ready1}, 0);
    tick();
    flush = 0; id_valid = 0;
    #1;
    chk("fl_ex_valid", {ex_valid2, ex_valid1}, 0);
    chk("fl_lu_stall", {lu_stall2, lu_stall1}, 0);
    chk("fl_id_ready", {id_ready2, id_ready1}, 2'b11);
    chk("fl_data_kept", ex_true_rs1[31:0], 32'h77);

    // Reset while LOAD_LAT=2 instance is mid-wait.
    id_valid = 1; ex_ready = 1; ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5;
    tick();
    rst = 1; clear_stages();
    tick();
    rst = 0; id_valid = 0;
    #1;
    chk("rw_lu_stall", lu_stall2, 0);
    chk("rw_id_ready", id_ready2, 1);
    chk("rw_ex_valid", ex_valid2, 0);
    chk("rw_true_rs", ex_true_rs2, 0);

    // Random forwarding sweep with narrow address range to force stage collisions.
    do_reset();
    id_valid = 1;
    for (int n = 0; n < 40; n++) begin
      id_is_rs = 2'($urandom_range(0, 3));
      id_rs_addr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_rs_data = {$urandom, $urandom}; id_other_data = {$urandom, $urandom};
      ex_wr_en = 1'($urandom_range(0, 1)); ex_wr_addr = 5'($urandom_range(0, 3));
      ex_wr_data = $urandom;
      mem_wr_en = 1'($urandom_range(0, 1)); mem_wr_addr = 5'($urandom_range(0, 3));
      mem_wr_data = $urandom;
      wb_wr_en = 1'($urandom_range(0, 1)); wb_wr_addr = 5'($urandom_range(0, 3));
      wb_wr_data = $urandom;
      e0 = mdl(id_rs_addr[4:0], id_rs_data[31:0]);
      e1 = mdl(id_rs_addr[9:5], id_rs_data[63:32]);
      tick();
      chk($sformatf("rnd%0d_true_rs", n), ex_true_rs1, {e1, e0});
      chk($sformatf("rnd%0d_operand", n), ex_operand1,
          {id_is_rs[1] ? e1 : id_other_data[63:32], id_is_rs[0] ? e0 : id_other_data[31:0]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
